// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int unsigned MEM_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_MAN  = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way picker: fixed manual priority or alternate on ties.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter bit MANUAL_PRIORITY = 1'b0
) (
  input  logic    inst_req,
  input  logic    man_req,
  input  req_id_e last_grant,
  output logic    grant_valid,
  output req_id_e grant_id
);

  always_comb begin
    grant_valid = inst_req | man_req;
    grant_id    = REQ_INST;
    if (inst_req && man_req) begin
      grant_id = (MANUAL_PRIORITY || last_grant == REQ_INST) ? REQ_MAN : REQ_INST;
    end else if (man_req) begin
      grant_id = REQ_MAN;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester sequencer driving the memory instance-port strobes with a
// programmable strobe width, address range check and saturating error count.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES   = 1,
  parameter int unsigned MEM_WORDS       = MEM_WORDS_DEFAULT,
  parameter bit          MANUAL_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_req,
  input  logic              inst_we,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_done,
  output logic              inst_err,
  input  logic              man_req,
  input  logic              man_we,
  input  logic [ADDR_W-1:0] man_addr,
  input  logic [DATA_W-1:0] man_wdata,
  output logic              man_done,
  output logic              man_err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [7:0]        err_count
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  req_id_e           winner_q, winner_d;
  req_id_e           last_grant_q, last_grant_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              inst_done_q, inst_done_d, man_done_q, man_done_d;
  logic              inst_err_q, inst_err_d, man_err_q, man_err_d;

  logic              grant_valid;
  req_id_e           grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;

  mem_arb_rr_pick #(
    .MANUAL_PRIORITY(MANUAL_PRIORITY)
  ) u_pick (
    .inst_req   (inst_req),
    .man_req    (man_req),
    .last_grant (last_grant_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign sel_we       = (grant_id == REQ_MAN) ? man_we    : inst_we;
  assign sel_addr     = (grant_id == REQ_MAN) ? man_addr  : inst_addr;
  assign sel_wdata    = (grant_id == REQ_MAN) ? man_wdata : inst_wdata;
  assign sel_in_range = (32'(sel_addr) < MEM_WORDS);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    err_d        = err_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;
    err_count_d  = err_count_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    inst_done_d  = 1'b0;
    man_done_d   = 1'b0;
    inst_err_d   = 1'b0;
    man_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          winner_d = grant_id;
          we_d     = sel_we;
          if (sel_in_range) begin
            // Strobes are registered so they rise in the first ACCESS cycle.
            err_d       = 1'b0;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            cnt_d       = 4'(ACCESS_CYCLES - 1);
            rd_d        = !sel_we;
            wr_d        = sel_we;
            state_d     = ACCESS;
          end else begin
            err_d       = 1'b1;
            inst_done_d = (grant_id == REQ_INST);
            man_done_d  = (grant_id == REQ_MAN);
            inst_err_d  = (grant_id == REQ_INST);
            man_err_d   = (grant_id == REQ_MAN);
            state_d     = RESP;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          rd_d  = rd_q;
          wr_d  = wr_q;
        end else begin
          if (!we_q) rdata_d = mem_rdata;
          inst_done_d = (winner_q == REQ_INST);
          man_done_d  = (winner_q == REQ_MAN);
          state_d     = RESP;
        end
      end
      RESP: begin
        last_grant_d = winner_q;
        if (err_q && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      winner_q     <= REQ_INST;
      last_grant_q <= REQ_MAN;
      rdata_q      <= '0;
      err_count_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      inst_done_q  <= 1'b0;
      man_done_q   <= 1'b0;
      inst_err_q   <= 1'b0;
      man_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      err_q        <= err_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
      err_count_q  <= err_count_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      inst_done_q  <= inst_done_d;
      man_done_q   <= man_done_d;
      inst_err_q   <= inst_err_d;
      man_err_q    <= man_err_d;
    end
  end

  assign inst_done        = inst_done_q;
  assign man_done         = man_done_q;
  assign inst_err         = inst_err_q;
  assign man_err          = man_err_q;
  assign rdata            = rdata_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign mem_read         = rd_q;
  assign mem_write_enable = wr_q;
  assign busy             = (state_q != IDLE);
  assign err_count        = err_count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench with a completion scoreboard for the memory-port arbiter.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        inst_req, inst_we, inst_done, inst_err;
  logic [19:0] inst_addr;
  logic [15:0] inst_wdata;
  logic        man_req, man_we, man_done, man_err;
  logic [19:0] man_addr;
  logic [15:0] man_wdata;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [19:0] mem_addr;
  logic        mem_read, mem_write_enable, busy;
  logic [7:0]  err_count;

  logic        b_inst_req, b_inst_we, b_inst_done, b_inst_err;
  logic [19:0] b_inst_addr;
  logic [15:0] b_inst_wdata;
  logic        b_man_req, b_man_we, b_man_done, b_man_err;
  logic [19:0] b_man_addr;
  logic [15:0] b_man_wdata;
  logic [15:0] b_rdata, b_mem_wdata, b_mem_rdata;
  logic [19:0] b_mem_addr;
  logic        b_mem_read, b_mem_write_enable, b_busy;
  logic [7:0]  b_err_count;

  mem_port_arbiter #(.ACCESS_CYCLES(1), .MEM_WORDS(1024), .MANUAL_PRIORITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_we(inst_we), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_done(inst_done), .inst_err(inst_err),
    .man_req(man_req), .man_we(man_we), .man_addr(man_addr), .man_wdata(man_wdata),
    .man_done(man_done), .man_err(man_err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write_enable(mem_write_enable), .mem_rdata(mem_rdata),
    .busy(busy), .err_count(err_count)
  );

  mem_port_arbiter #(.ACCESS_CYCLES(4), .MEM_WORDS(1024), .MANUAL_PRIORITY(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .inst_req(b_inst_req), .inst_we(b_inst_we), .inst_addr(b_inst_addr), .inst_wdata(b_inst_wdata),
    .inst_done(b_inst_done), .inst_err(b_inst_err),
    .man_req(b_man_req), .man_we(b_man_we), .man_addr(b_man_addr), .man_wdata(b_man_wdata),
    .man_done(b_man_done), .man_err(b_man_err),
    .rdata(b_rdata), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read),
    .mem_write_enable(b_mem_write_enable), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .err_count(b_err_count)
  );

  logic [15:0] mem   [1024];
  logic [15:0] b_mem [1024];
  assign mem_rdata   = mem[mem_addr[9:0]];
  assign b_mem_rdata = b_mem[b_mem_addr[9:0]];
  always @(posedge clk) if (mem_write_enable) mem[mem_addr[9:0]] <= mem_wdata;
  always @(posedge clk) if (b_mem_write_enable) b_mem[b_mem_addr[9:0]] <= b_mem_wdata;

  typedef struct {
    req_id_e     id;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] shadow [1024];
  logic [15:0] exp_rd = 16'h0000;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input req_id_e id, input logic we, input logic [19:0] addr,
                       input logic [15:0] wd, input logic on);
    if (id == REQ_INST) begin
      inst_req = on; inst_we = we; inst_addr = addr; inst_wdata = wd;
    end else begin
      man_req = on; man_we = we; man_addr = addr; man_wdata = wd;
    end
  endtask

  task automatic push_exp(input req_id_e id, input logic we, input logic [19:0] addr,
                          input logic [15:0] wd);
    exp_t e;
    e.id  = id;
    e.err = (addr >= 20'd1024);
    if (!e.err) begin
      if (we) shadow[addr[9:0]] = wd;
      else exp_rd = shadow[addr[9:0]];
    end
    e.rdata = exp_rd;
    sb.push_back(e);
  endtask

  // Counts negedges from now until a done is seen, then scores it.
  task automatic wait_resp(output int lat, output int wr, output int rd, output bit ok);
    exp_t e;
    lat = 0; wr = 0; rd = 0; ok = 1'b0;
    while (!ok && lat < 60) begin
      @(negedge clk);
      lat++;
      if (mem_write_enable) wr++;
      if (mem_read) rd++;
      chk("one_strobe", {31'd0, mem_read & mem_write_enable}, 32'd0);
      if (inst_done || man_done) ok = 1'b1;
    end
    if (!ok) begin
      chk("done_timeout", {31'd0, inst_done | man_done}, 32'd1);
    end else if (sb.size() == 0) begin
      chk("sb_empty", sb.size(), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("inst_done", {31'd0, inst_done}, {31'd0, e.id == REQ_INST});
      chk("man_done",  {31'd0, man_done},  {31'd0, e.id == REQ_MAN});
      chk("inst_err",  {31'd0, inst_err},  {31'd0, e.id == REQ_INST && e.err});
      chk("man_err",   {31'd0, man_err},   {31'd0, e.id == REQ_MAN && e.err});
      chk("rdata",     {16'd0, rdata},     {16'd0, e.rdata});
    end
  endtask

  task automatic do_req(input req_id_e id, input logic we, input logic [19:0] addr,
                        input logic [15:0] wd);
    int lat, wr, rd;
    bit ok;
    logic err;
    err = (addr >= 20'd1024);
    drive(id, we, addr, wd, 1'b1);
    push_exp(id, we, addr, wd);
    wait_resp(lat, wr, rd, ok);
    if (ok) begin
      chk("latency", lat, err ? 32'd2 : 32'd3);
      chk("wr_cycles", wr, (we && !err) ? 32'd1 : 32'd0);
      chk("rd_cycles", rd, (!we && !err) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    drive(id, we, addr, wd, 1'b0);
  endtask

  initial begin
    int lat, wr, rd, first, last, n, dn;
    bit ok;
    rst_n = 1'b0;
    drive(REQ_INST, 1'b0, '0, '0, 1'b0);
    drive(REQ_MAN, 1'b0, '0, '0, 1'b0);
    b_inst_req = 0; b_inst_we = 0; b_inst_addr = '0; b_inst_wdata = '0;
    b_man_req = 0; b_man_we = 0; b_man_addr = '0; b_man_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write_enable}, 32'd0);
    chk("rst_done_err", {28'd0, inst_done, man_done, inst_err, man_err}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_mem_addr", {12'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_b_busy", {31'd0, b_busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(REQ_INST, 1'b1, 20'h0000A, 16'h1234);
    chk("mem_write_0x00A", {16'd0, mem[10]}, 32'h1234);
    do_req(REQ_INST, 1'b0, 20'h0000A, 16'h0000);
    do_req(REQ_MAN, 1'b1, 20'h003FF, 16'h5A5A);
    do_req(REQ_MAN, 1'b0, 20'h003FF, 16'h0000);

    do_req(REQ_MAN, 1'b0, 20'h00400, 16'h0000);
    chk("err_count_1", {24'd0, err_count}, 32'd1);
    chk("mem_addr_hold", {12'd0, mem_addr}, 32'h003FF);

    // Both requesters held through four completions: inst wins the first tie.
    drive(REQ_INST, 1'b1, 20'h00001, 16'h1111, 1'b1);
    drive(REQ_MAN, 1'b1, 20'h00002, 16'h2222, 1'b1);
    for (int unsigned k = 0; k < 4; k++) begin
      push_exp((k % 2 == 0) ? REQ_INST : REQ_MAN, 1'b1,
               (k % 2 == 0) ? 20'h00001 : 20'h00002,
               (k % 2 == 0) ? 16'h1111 : 16'h2222);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      wait_resp(lat, wr, rd, ok);
      if (ok) begin
        chk("tie_period", lat, 32'd3);
        chk("tie_wr_cycles", wr, 32'd1);
      end
    end
    @(posedge clk); #1;
    drive(REQ_INST, 1'b0, '0, '0, 1'b0);
    drive(REQ_MAN, 1'b0, '0, '0, 1'b0);
    chk("tie_mem_1", {16'd0, mem[1]}, 32'h1111);
    chk("tie_mem_2", {16'd0, mem[2]}, 32'h2222);

    for (int unsigned i = 0; i < 253; i++) begin
      do_req(i[0] ? REQ_MAN : REQ_INST, i[1], (i[2] ? 20'hFFFFF : 20'h00400 + 20'(i)), 16'h0);
    end
    chk("err_count_254", {24'd0, err_count}, 32'd254);
    for (int unsigned i = 0; i < 6; i++) begin
      do_req(i[0] ? REQ_MAN : REQ_INST, 1'b0, 20'h80000, 16'h0);
    end
    chk("err_count_sat", {24'd0, err_count}, 32'd255);

    // Four-cycle strobe on the second instance.
    b_man_req = 1; b_man_we = 1; b_man_addr = 20'h003FF; b_man_wdata = 16'hBEEF;
    n = 0; wr = 0; first = 0; last = 0; ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      if (b_mem_write_enable) begin
        wr++;
        if (first == 0) first = n;
        last = n;
      end
      if (b_man_done || b_inst_done) ok = 1'b1;
    end
    chk("b_done_seen", {31'd0, b_man_done}, 32'd1);
    chk("b_wr_cycles", wr, 32'd4);
    chk("b_wr_consecutive", last - first + 1, 32'd4);
    chk("b_latency", n, 32'd6);
    chk("b_man_err", {31'd0, b_man_err}, 32'd0);
    @(posedge clk); #1;
    b_man_req = 0;
    chk("b_mem_0x3FF", {16'd0, b_mem[1023]}, 32'hBEEF);

    b_inst_req = 1; b_inst_we = 1; b_inst_addr = 20'h5; b_inst_wdata = 16'h0505;
    b_man_req = 1; b_man_we = 1; b_man_addr = 20'h6; b_man_wdata = 16'h0606;
    n = 0; ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      if (b_man_done || b_inst_done) ok = 1'b1;
    end
    chk("b_prio_man_done", {31'd0, b_man_done}, 32'd1);
    chk("b_prio_inst_done", {31'd0, b_inst_done}, 32'd0);
    @(posedge clk); #1;
    b_inst_req = 0; b_man_req = 0;
    @(posedge clk); #1;

    // Asynchronous reset while a read strobe is high.
    b_man_req = 1; b_man_we = 0; b_man_addr = 20'h003FF;
    n = 0;
    while (!b_mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_read_strobe_seen", {31'd0, b_mem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_mem_read", {31'd0, b_mem_read}, 32'd0);
    chk("rst_async_busy", {31'd0, b_busy}, 32'd0);
    chk("rst_async_b_err_count", {24'd0, b_err_count}, 32'd0);
    chk("rst_async_err_count", {24'd0, err_count}, 32'd0);
    b_man_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (b_man_done || b_inst_done) dn++;
    end
    chk("rst_no_done", dn, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and two-requester arbiter in front of the 1024-word, 16-bit memory array. Accepts word read/write requests from the instance requester (bus-interface unit) and the manual requester (loader/debug console). Serialises them onto the memory's instance-port strobes with a programmable strobe width, range-checks every address, and returns read data, completion and error to the winner. The memory's manual-port strobes are tied low when this block is used.

## Interface
- ACCESS_CYCLES, default 1: cycles each read/write strobe is held, legal range 1–15.
- MEM_WORDS, default 1024: number of implemented words; addresses ≥ MEM_WORDS are errors.
- MANUAL_PRIORITY, default 0: 0 selects round-robin arbitration; 1 makes manual always win a tie.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inst_req / man_req  in  1  request, held until matching done.
- inst_we / man_we  in  1  1 = write, 0 = read; stable while req.
- inst_addr / man_addr  in  20  word address; stable while req.
- inst_wdata / man_wdata  in  16  write data; stable while req.
- inst_done / man_done  out  1  one-cycle completion pulse.
- inst_err / man_err  out  1  valid with done; out-of-range address.
- rdata  out  16  read result; valid with either done, held until next completion.
- mem_addr  out  20  to memory instance_address.
- mem_wdata  out  16  to memory data_in.
- mem_read  out  1  to memory instance_read.
- mem_write_enable  out  1  to memory instance_write_enable.
- mem_rdata  in  16  from memory data_out.
- busy  out  1  high in any state other than IDLE.
- err_count  out  8  saturating count of errored requests.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if neither req is high, stay. Otherwise pick a winner and latch its we, addr and wdata into internal registers.
  - In-range address: load cnt = ACCESS_CYCLES−1 and go to ACCESS.
  - Address ≥ MEM_WORDS: set err, issue no strobe, go to RESP.
- Arbitration:
  - Only one requester active: that requester wins.
  - Both active, MANUAL_PRIORITY=1: manual wins.
  - Both active, MANUAL_PRIORITY=0: the requester not granted last wins. last_grant resets to manual, so instance wins the first tie.
- ACCESS:
  - mem_addr is driven from the latched address.
  - mem_read = !we; mem_write_enable = we. Exactly one is high, never both.
  - mem_wdata is driven from the latched data.
  - If cnt≠0, decrement. If cnt==0, capture mem_rdata into rdata (reads only) and go to RESP.
- RESP:
  - Strobes are low.
  - The winner's done is high for one cycle, with its err.
  - last_grant is updated.
  - If err, err_count increments, saturating at 255.
  - Go to IDLE.
- rdata is unchanged by writes and by errored requests.
- Outside ACCESS: mem_read = mem_write_enable = 0; mem_addr and mem_wdata hold their last value.

## Timing
- Reset (async assert, synchronous release):
  - state=IDLE; all strobes, done, err and busy = 0.
  - rdata = 0; err_count = 0; mem_addr = 0; mem_wdata = 0; last_grant = manual.
- Reset asserted mid-ACCESS drops the strobes immediately, without waiting for a clock edge. The interrupted request is lost and gets no done.
- Latency, in-range request, req sampled at edge N:
  - Strobe high in cycles N+1 … N+ACCESS_CYCLES.
  - done high in cycle N+ACCESS_CYCLES+1.
  - Next grant is sampled at the edge ending cycle N+ACCESS_CYCLES+2.
- Latency, error request sampled at edge N: done+err high in cycle N+1.
- Handshake rule: a requester samples done at the edge ending RESP and must drop req at that same edge. A req still high in IDLE is a new request.
- Throughput: one access per ACCESS_CYCLES+2 cycles.
- A req that rises while another request is in ACCESS/RESP waits. It is never dropped.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - requester IDs (REQ_INST, REQ_MAN);
  - constant MEM_WORDS_DEFAULT = 1024;
  - address width 20 and data width 16.
- Sub-module mem_arb_rr_pick: combinational two-way picker.
  - Inputs: inst_req, man_req, last_grant, MANUAL_PRIORITY.
  - Outputs: grant_valid, grant_id.

## Test plan
- Write then read, ACCESS_CYCLES=1:
  - inst write 0x00A ← 0x1234; mem_write_enable is high exactly 1 cycle and inst_done follows 1 cycle later.
  - inst read 0x00A → rdata=0x1234, inst_err=0.
- Tie, MANUAL_PRIORITY=0, both requesters held continuously:
  - Grant order is inst, man, inst, man.
  - Each done arrives 3 cycles after its grant.
- Out of range: man read 0x00400 → man_done+man_err in the cycle after the request is sampled.
  - No strobe is issued; err_count=1; rdata unchanged.
- ACCESS_CYCLES=4 write of 0xBEEF to 0x3FF: mem_write_enable is high for exactly 4 consecutive cycles, then man_done.
- Reset during ACCESS:
  - rst_n low mid-strobe → mem_read drops to 0 with no clock edge.
  - No done is issued; busy=0; err_count=0.
- Saturation: 260 errored requests → err_count=255.
